// File: rtl/pokemon_pkg.sv
// Shared definitions for the overworld player movement slice.
//   dir_t       : facing encoding (0 down, 1 up, 2 left, 3 right)
//   mv_state_t  : movement controller states
//   KEY_W/A/S/D : USB HID keycodes that map to directions
//   *_DEF       : default map geometry used as module parameter defaults
package pokemon_pkg;

  localparam int MAP_W_DEF = 320;
  localparam int MAP_H_DEF = 240;
  localparam int TILE_DEF  = 16;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    MOVE  = 3'd4
  } mv_state_t;

endpackage

// File: rtl/player_move_ctrl_coll_addr_calc.sv
// coll_addr_calc: registered tile-centre address for the collision map.
//   addr = (ty + TILE/2) * MAP_W + (tx + TILE/2), loaded when load is high.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset (addr clears to 0)
//   load       : capture a new address this cycle
//   tx, ty     : target tile top-left in map pixels
//   addr       : collision memory read address (holds between loads)
module coll_addr_calc #(
  parameter int MAP_W  = 320,
  parameter int TILE   = 16,
  parameter int ADDR_W = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [8:0]        tx,
  input  logic [7:0]        ty,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] cx;
  logic [ADDR_W-1:0] cy;
  logic [ADDR_W-1:0] row_base;

  // Probe the tile centre so a pixel-exact collision map is sampled mid-tile.
  assign cx = ADDR_W'(tx) + ADDR_W'(TILE / 2);
  assign cy = ADDR_W'(ty) + ADDR_W'(TILE / 2);

  // Constant multiply by the map width; 320 = 256 + 64 reduces to two shifts.
  generate
    if (MAP_W == 320) begin : g_mul320
      assign row_base = (cy << 8) + (cy << 6);
    end else begin : g_mul_gen
      assign row_base = cy * ADDR_W'(MAP_W);
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= row_base + cx;
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: overworld player movement controller.
// A direction key on a frame tick turns the player, looks up the target tile
// in the collision map (1-cycle read latency) and, if walkable, slides the
// player one tile over successive frame ticks.
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   keycode           : USB HID keycode (W/A/S/D map to directions)
//   run_key           : run modifier (used only when PLAYER_RUN_EN is defined)
//   coll_read_address : collision memory read address (registered)
//   coll_data         : collision memory data, 0 = walkable
//   pos_x, pos_y      : player tile top-left in map pixels
//   facing            : 0 down, 1 up, 2 left, 3 right
//   walk_frame        : animation frame index
//   moving            : high while a step is being animated
//   state_dbg         : current controller state (mv_state_t encoding)
// Build option: define PLAYER_RUN_EN to advance 2 px per tick while run_key
// is held, with the walk animation running twice as fast.
module player_move_ctrl
  import pokemon_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int TILE    = TILE_DEF,
  parameter int START_X = 160,
  parameter int START_Y = 112,
  parameter int ADDR_W  = 17
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [7:0]        keycode,
  input  logic              run_key,
  output logic [ADDR_W-1:0] coll_read_address,
  input  logic [3:0]        coll_data,
  output logic [8:0]        pos_x,
  output logic [7:0]        pos_y,
  output logic [1:0]        facing,
  output logic [1:0]        walk_frame,
  output logic              moving,
  output logic [2:0]        state_dbg
);

  mv_state_t  state_q, state_d;
  logic [8:0] tgt_x_q, tgt_x_d;
  logic [7:0] tgt_y_q, tgt_y_d;
  logic [8:0] pos_x_d;
  logic [7:0] pos_y_d;
  logic [1:0] facing_d;
  logic [1:0] walk_d;
  logic [1:0] sub_q, sub_d;
  logic       moving_d;

  logic       key_vld;
  dir_t       key_dir;
  logic [9:0] cand_x;
  logic [8:0] cand_y;
  logic       in_bounds;
  logic [1:0] step_px;
  logic [8:0] nxt_x;
  logic [7:0] nxt_y;
  logic       arrive;
  logic [2:0] sub_sum;

  assign state_dbg = state_q;

`ifdef PLAYER_RUN_EN
  assign step_px = run_key ? 2'd2 : 2'd1;
`else
  logic unused_run_key;
  assign unused_run_key = run_key;
  assign step_px = 2'd1;
`endif

  // Key decode
  always_comb begin
    key_vld = 1'b1;
    key_dir = DOWN;
    case (keycode)
      KEY_W:   key_dir = UP;
      KEY_S:   key_dir = DOWN;
      KEY_A:   key_dir = LEFT;
      KEY_D:   key_dir = RIGHT;
      default: key_vld = 1'b0;
    endcase
  end

  // Candidate target one tile away; one extra bit catches under/overflow.
  always_comb begin
    cand_x    = {1'b0, pos_x};
    cand_y    = {1'b0, pos_y};
    in_bounds = 1'b0;
    case (key_dir)
      LEFT: begin
        cand_x    = {1'b0, pos_x} - 10'(TILE);
        in_bounds = ({1'b0, pos_x} >= 10'(TILE));
      end
      RIGHT: begin
        cand_x    = {1'b0, pos_x} + 10'(TILE);
        in_bounds = (cand_x <= 10'(MAP_W - TILE));
      end
      UP: begin
        cand_y    = {1'b0, pos_y} - 9'(TILE);
        in_bounds = ({1'b0, pos_y} >= 9'(TILE));
      end
      default: begin
        cand_y    = {1'b0, pos_y} + 9'(TILE);
        in_bounds = (cand_y <= 9'(MAP_H - TILE));
      end
    endcase
  end

  // Position after one tick of motion; only one axis ever differs.
  always_comb begin
    nxt_x = pos_x;
    nxt_y = pos_y;
    if (pos_x < tgt_x_q)      nxt_x = pos_x + 9'(step_px);
    else if (pos_x > tgt_x_q) nxt_x = pos_x - 9'(step_px);
    if (pos_y < tgt_y_q)      nxt_y = pos_y + 8'(step_px);
    else if (pos_y > tgt_y_q) nxt_y = pos_y - 8'(step_px);
  end

  assign arrive = (nxt_x == tgt_x_q) && (nxt_y == tgt_y_q);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE/MOVE are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick && key_vld && in_bounds) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    state_d = CHECK;
      CHECK:   state_d = (coll_data == 4'h0) ? MOVE : IDLE;
      MOVE:    if (frame_tick && arrive) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    facing_d = facing;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    pos_x_d  = pos_x;
    pos_y_d  = pos_y;
    sub_d    = sub_q;
    walk_d   = walk_frame;
    sub_sum  = {1'b0, sub_q} + {1'b0, step_px};
    case (state_q)
      IDLE: begin
        if (frame_tick && key_vld) begin
          facing_d = key_dir;
          if (in_bounds) begin
            tgt_x_d = cand_x[8:0];
            tgt_y_d = cand_y[7:0];
          end
        end
      end
      CHECK: begin
        sub_d  = 2'd0;
        walk_d = 2'd0;
      end
      MOVE: begin
        if (frame_tick) begin
          pos_x_d = nxt_x;
          pos_y_d = nxt_y;
          // Sub-counter carry paces the animation: every 4 walk ticks or
          // every 2 run ticks.
          sub_d   = sub_sum[1:0];
          if (sub_sum[2]) walk_d = walk_frame + 2'd1;
          if (arrive)     walk_d = 2'd0;
        end
      end
      default: ;
    endcase
    moving_d = (state_d == MOVE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x      <= 9'(START_X);
      pos_y      <= 8'(START_Y);
      tgt_x_q    <= 9'(START_X);
      tgt_y_q    <= 8'(START_Y);
      facing     <= DOWN;
      walk_frame <= 2'd0;
      sub_q      <= 2'd0;
      moving     <= 1'b0;
    end else begin
      pos_x      <= pos_x_d;
      pos_y      <= pos_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      facing     <= facing_d;
      walk_frame <= walk_d;
      sub_q      <= sub_d;
      moving     <= moving_d;
    end
  end

  // The registered address becomes valid on the REQ -> WAIT edge.
  coll_addr_calc #(
    .MAP_W (MAP_W),
    .TILE  (TILE),
    .ADDR_W(ADDR_W)
  ) u_coll_addr_calc (
    .Clk  (Clk),
    .Reset(Reset),
    .load (state_q == REQ),
    .tx   (tgt_x_q),
    .ty   (tgt_y_q),
    .addr (coll_read_address)
  );

endmodule
